// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART transmitter.
// The FSM state set includes Parity, used only when UART_HOST_PARITY_EN is defined.
package uart_host_pkg;

  typedef enum logic [2:0] {
    Idle   = 3'd0,
    Start  = 3'd1,
    Data   = 3'd2,
    Stop   = 3'd3,
    Parity = 3'd4
  } state_t;

  localparam int DataBits = 8;
  localparam int StopBits = 1;

  function automatic int clocks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous byte FIFO with registered count, push/pop/full/empty and no fall-through.
module uart_host_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == (AddrW+1)'(Depth));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count do, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AddrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AddrW+1)'(1);
        2'b01:   count <= count - (AddrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: buffered bytes serialised as 8N1 frames on tx_o.
// Define UART_HOST_PARITY_EN to insert an even-parity bit between data and stop.
module uart_host_tx
  import uart_host_pkg::*;
#(
  parameter int ClkFreqHz = 12000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [7:0]                  data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FifoDepth):0]  fifo_count_o
);

  localparam int ClocksPerBit = clocks_per_bit(ClkFreqHz, BaudRate);
  localparam int CntW         = (ClocksPerBit < 2) ? 1 : $clog2(ClocksPerBit);

  generate
    if (ClocksPerBit < 2) begin : g_bad_baud
      $error("uart_host_tx: ClkFreqHz / BaudRate must be at least 2");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
      $error("uart_host_tx: FifoDepth must be a power of two and at least 2");
    end
  endgenerate

  state_t              state;
  logic [CntW-1:0]     baud_cnt;
  logic [2:0]          bit_idx;
  logic [DataBits-1:0] shift;
  logic [DataBits-1:0] head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                bit_end;
  logic                tx_next;
`ifdef UART_HOST_PARITY_EN
  logic                parity_bit;
`endif

  assign ready_o = ~full;
  assign push    = valid_i & ~full;
  assign bit_end = (baud_cnt == CntW'(ClocksPerBit - 1));
  // Pop from Idle, or at the last stop cycle so the next start bit follows with no gap.
  assign pop     = ~empty & ((state == Idle) | ((state == Stop) & bit_end));
  assign busy_o  = (state != Idle) | ~empty;

  uart_host_fifo #(
    .Width (DataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (push),
    .push_data (data_i),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= Idle;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_HOST_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      baud_cnt <= (state == Idle || bit_end) ? '0 : baud_cnt + CntW'(1);
      if (pop) begin
        shift <= head;
`ifdef UART_HOST_PARITY_EN
        parity_bit <= ^head;
`endif
      end
      case (state)
        Idle:  if (pop) state <= Start;
        Start: if (bit_end) begin
          state   <= Data;
          bit_idx <= '0;
        end
        Data:  if (bit_end) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'(DataBits - 1)) begin
`ifdef UART_HOST_PARITY_EN
            state <= Parity;
`else
            state <= Stop;
`endif
          end
        end
`ifdef UART_HOST_PARITY_EN
        Parity: if (bit_end) state <= Stop;
`endif
        Stop:  if (bit_end) state <= pop ? Start : Idle;
        default: state <= Idle;
      endcase
    end
  end

  // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    tx_next = 1'b1;
    case (state)
      Start:   tx_next = 1'b0;
      Data:    tx_next = shift[0];
`ifdef UART_HOST_PARITY_EN
      Parity:  tx_next = parity_bit;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // The line is a bare flop, one cycle behind the state that selects its level.
  always_ff @(posedge clk_i) begin
    if (reset_i) tx_o <= 1'b1;
    else         tx_o <= tx_next;
  end

endmodule
